// File: rtl/soc_stream_pkg.sv
// Shared definitions for the SoC valid/ready stream blocks.
// Buffer depth and beat layout live here so downstream stream stages agree on them.
package soc_stream_pkg;

  localparam int STREAM_BUF_DEPTH = 2;
  localparam int STREAM_DATA_W    = 32;
  localparam int STREAM_CNT_W     = $clog2(STREAM_BUF_DEPTH + 1);

  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
    logic                     last;
  } stream_beat_t;

endpackage

// File: rtl/fifo_stream_bridge_if.sv
// Handshake bundle between the FIFO read port, the bridge and the stream consumer.
// master is the bridge side; slave is the FIFO/consumer environment.
interface fifo_stream_bridge_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  i_enable;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_rd_data;
  logic                  o_fifo_rd_en;
  logic                  o_m_valid;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  o_m_last;
  logic                  i_m_ready;

  modport master (
    input  i_enable, i_fifo_empty, i_fifo_rd_data, i_m_ready,
    output o_fifo_rd_en, o_m_valid, o_m_data, o_m_last
  );

  modport slave (
    output i_enable, i_fifo_empty, i_fifo_rd_data, i_m_ready,
    input  o_fifo_rd_en, o_m_valid, o_m_data, o_m_last
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry in-order register buffer; slot0 is always the head word.
module stream_skid_buf
  import soc_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_push_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_head,
  output logic [STREAM_CNT_W-1:0] o_count
);

  logic [DATA_WIDTH-1:0]   slot0;
  logic [DATA_WIDTH-1:0]   slot1;
  logic [STREAM_CNT_W-1:0] count;
  logic [STREAM_CNT_W-1:0] wr_idx;
  logic                    pop_ok;

  assign pop_ok = i_pop && (count != '0);
  // A simultaneous pop shifts the head first, so the new word lands one slot lower.
  assign wr_idx = count - STREAM_CNT_W'(pop_ok);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      if (pop_ok) slot0 <= slot1;
      if (i_push && (wr_idx == STREAM_CNT_W'(0))) slot0 <= i_push_data;
      if (i_push && (wr_idx == STREAM_CNT_W'(1))) slot1 <= i_push_data;
      count <= count + STREAM_CNT_W'(i_push) - STREAM_CNT_W'(pop_ok);
    end
  end

  assign o_head  = slot0;
  assign o_count = count;

endmodule

// File: rtl/fifo_stream_bridge.sv
// Read-side adapter from a registered-read Sync_FIFO to a valid/ready stream,
// framing the words into fixed-length bursts with a last marker.
module fifo_stream_bridge
  import soc_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  fifo_stream_bridge_if.master bus
);

  localparam int              BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam int              OCC_W     = STREAM_CNT_W + 1;

  logic [STREAM_CNT_W-1:0] count;
  logic [DATA_WIDTH-1:0]   head;
  logic [OCC_W-1:0]        occupancy;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    inflight;
  logic                    valid;
  logic                    pop;
  logic                    rd_en;

  assign valid = (count != '0);
  assign pop   = valid && bus.i_m_ready;

  // Counting the same-cycle pop lets a read issue the moment ready returns.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign rd_en     = i_rstn && bus.i_enable && !bus.i_fifo_empty
                     && (occupancy < OCC_W'(STREAM_BUF_DEPTH));

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (inflight),
    .i_push_data (bus.i_fifo_rd_data),
    .i_pop       (pop),
    .o_head      (head),
    .o_count     (count)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= rd_en;
      if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_m_valid    = valid;
  assign bus.o_m_data     = head;
  assign bus.o_m_last     = valid && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_fifo_stream_bridge.sv
// Bench for fifo_stream_bridge: behavioural Sync_FIFO, expected-word queue with
// burst positions fixed at write time, and a negedge monitor on the stream side.
module tb_fifo_stream_bridge;
  import soc_stream_pkg::*;

  localparam int DW = 32;
  localparam int BL = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_bridge_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_bridge #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_pending[$];
  stream_beat_t  exp_q[$];
  int            wr_count = 0;
  int            reads    = 0;
  int            accepted = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  stream_beat_t  mon_beat;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enable, input logic ready);
    bus.i_enable  = enable;
    bus.i_m_ready = ready;
    #1;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Burst position is the word's index since reset, since nothing is lost or reordered.
  task automatic writeWord(input logic [DW-1:0] w);
    stream_beat_t b;
    wr_pending.push_back(w);
    b.data = w;
    b.last = ((wr_count % BL) == BL - 1);
    wr_count++;
    exp_q.push_back(b);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    #1;
    checkOutput("reset_valid", bus.o_m_valid, 0);
    checkOutput("reset_data", bus.o_m_data, 0);
    checkOutput("reset_last", bus.o_m_last, 0);
    checkOutput("reset_rd_en", bus.o_fifo_rd_en, 0);
    exp_q.delete();
    wr_count = 0;
    reads    = 0;
    accepted = 0;
    stepCycles(2);
    rstn = 1'b1;
    stepCycles(1);
  endtask

  task automatic waitValid(input int budget, input string tag);
    int n = 0;
    while (!bus.o_m_valid && n < budget) begin
      stepCycles(1);
      n++;
    end
    checkOutput(tag, bus.o_m_valid, 1);
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      stepCycles(1);
      n++;
    end
    checkOutput(tag, exp_q.size(), 0);
  endtask

  // Sync_FIFO model: registered read data, writes become visible one edge later.
  always @(posedge clk) begin
    if (!rstn) begin
      fifo_q.delete();
      wr_pending.delete();
      bus.i_fifo_rd_data <= '0;
      bus.i_fifo_empty   <= 1'b1;
    end else begin
      if (bus.o_fifo_rd_en && fifo_q.size() > 0) bus.i_fifo_rd_data <= fifo_q.pop_front();
      while (wr_pending.size() > 0) fifo_q.push_back(wr_pending.pop_front());
      bus.i_fifo_empty <= (fifo_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) begin
        checkOutput("stall_valid", bus.o_m_valid, 1);
        checkOutput("stall_data", bus.o_m_data, prev_data);
      end
      if (bus.o_m_valid && bus.i_m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", bus.o_m_valid, 0);
        end else begin
          mon_beat = exp_q.pop_front();
          checkOutput("beat_data", bus.o_m_data, mon_beat.data);
          checkOutput("beat_last", bus.o_m_last, mon_beat.last);
          accepted++;
        end
      end
      if (bus.o_fifo_rd_en) begin
        reads++;
        checkOutput("rd_en_while_empty", bus.i_fifo_empty, 0);
        checkOutput("occupancy_le_2", 32'((reads - accepted) <= 2), 1);
      end
      prev_stall = bus.o_m_valid && !bus.i_m_ready;
      prev_data  = bus.o_m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int r0;
    int pushed;
    applyStimulus(1'b0, 1'b0);
    stepCycles(2);
    doReset();

    // Single word: read pulses once, valid two cycles after empty falls.
    applyStimulus(1'b1, 1'b1);
    writeWord(32'hA5A5_0001);
    stepCycles(1);
    checkOutput("single_rd_en_T", bus.o_fifo_rd_en, 1);
    checkOutput("single_valid_T", bus.o_m_valid, 0);
    stepCycles(1);
    checkOutput("single_rd_en_T1", bus.o_fifo_rd_en, 0);
    checkOutput("single_valid_T1", bus.o_m_valid, 0);
    stepCycles(1);
    checkOutput("single_valid_T2", bus.o_m_valid, 1);
    checkOutput("single_data_T2", bus.o_m_data, 32'hA5A5_0001);
    checkOutput("single_last_T2", bus.o_m_last, 0);
    stepCycles(1);
    checkOutput("single_valid_after", bus.o_m_valid, 0);
    checkOutput("single_reads", reads, 1);

    // Streaming 16 words back to back.
    doReset();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) writeWord(i);
    stepCycles(1);
    waitValid(10, "stream_first_valid");
    for (int i = 0; i < 16; i++) begin
      checkOutput("stream_valid", bus.o_m_valid, 1);
      checkOutput("stream_data", bus.o_m_data, i);
      checkOutput("stream_last", bus.o_m_last, 32'((i % BL) == BL - 1));
      stepCycles(1);
    end
    checkOutput("stream_reads", reads, 16);

    // Backpressure: only two words leave the FIFO while ready is low.
    doReset();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) writeWord(32'hB000_0000 + i);
    stepCycles(8);
    checkOutput("bp_reads", reads, 2);
    checkOutput("bp_fifo_left", fifo_q.size(), 6);
    checkOutput("bp_valid", bus.o_m_valid, 1);
    checkOutput("bp_head", bus.o_m_data, 32'hB000_0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("bp_ready_same_cycle_rd", bus.o_fifo_rd_en, 1);
    waitDrain(40, "bp_drain");
    checkOutput("bp_accepted", accepted, 8);

    // Random ready and random write pacing over 100 words.
    doReset();
    pushed = 0;
    for (int c = 0; c < 2000 && pushed < 100; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        writeWord($urandom);
        pushed++;
      end
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      stepCycles(1);
    end
    applyStimulus(1'b1, 1'b1);
    waitDrain(400, "rand_drain");
    checkOutput("rand_accepted", accepted, 100);

    // Enable gating mid-burst: no new reads, buffered words drain, burst position holds.
    doReset();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) writeWord(32'hE000_0000 + i);
    for (int c = 0; c < 20 && accepted < 2; c++) stepCycles(1);
    checkOutput("en_two_beats", accepted, 2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("en_rd_off_same_cycle", bus.o_fifo_rd_en, 0);
    r0 = reads;
    stepCycles(6);
    checkOutput("en_no_reads", reads, r0);
    checkOutput("en_drained", bus.o_m_valid, 0);
    applyStimulus(1'b1, 1'b1);
    waitDrain(40, "en_drain");
    checkOutput("en_accepted", accepted, 8);

    // Reset mid-stream with two words buffered.
    doReset();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) writeWord(32'hD000_0000 + i);
    stepCycles(6);
    checkOutput("mid_valid_before", bus.o_m_valid, 1);
    checkOutput("mid_reads_before", reads, 2);
    doReset();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) writeWord(32'hC000_0000 + i);
    stepCycles(1);
    waitValid(10, "mid_first_valid");
    checkOutput("mid_first_data", bus.o_m_data, 32'hC000_0000);
    checkOutput("mid_first_last", bus.o_m_last, 0);
    waitDrain(40, "mid_drain");
    checkOutput("mid_accepted", accepted, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
